// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_prefetch_queue
// Description : Instruction fetch front end. Issues sequential word fetches
//               to a variable-latency imem over req/ack, buffers returned
//               words with their PC in a DEPTH-entry FIFO, and presents the
//               head to decode over valid/ready. A redirect flushes the
//               buffer and restarts fetch at the (word-aligned) target.
// Options     : define PREFETCH_STATS_EN to add fetch_cnt / flush_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect,
  input  logic [31:0]               redirect_pc,
  output logic                      imem_req,
  output logic [31:0]               imem_addr,
  input  logic                      imem_ack,
  input  logic [31:0]               imem_data,
  output logic                      inst_valid,
  output logic [31:0]               inst,
  output logic [31:0]               inst_pc,
  input  logic                      inst_ready,
  output logic [$clog2(DEPTH):0]    count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]               fetch_cnt,
  output logic [15:0]               flush_cnt
`endif
);

  localparam int                c_ptr_w = $clog2(DEPTH);
  localparam int                c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t               r_state;
  logic [31:0]          r_fetch_pc;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [31:0]          r_mem_pc   [DEPTH];
  logic [31:0]          r_mem_data [DEPTH];
  logic [31:0]          r_head_pc;
  logic [31:0]          r_head_data;

  logic                 w_push;
  logic                 w_pop;
  logic [c_ptr_w-1:0]   w_rd_next;
  logic [c_cnt_w-1:0]   w_cnt_after_pop;
  logic [c_cnt_w-1:0]   w_cnt_next;
  logic                 w_head_bypass;

  // A redirect cancels both the handshake and the pop of its cycle.
  assign w_push          = (r_state == S_REQ) & imem_ack & ~redirect;
  assign w_pop           = (r_count != '0) & inst_ready & ~redirect;
  assign w_rd_next       = w_pop ? r_rd_ptr + c_ptr_w'(1) : r_rd_ptr;
  assign w_cnt_after_pop = r_count - c_cnt_w'(w_pop);
  assign w_cnt_next      = w_cnt_after_pop + c_cnt_w'(w_push);
  // The incoming word becomes the next head when nothing older remains.
  assign w_head_bypass   = w_push & (w_cnt_after_pop == '0);

  assign imem_req   = (r_state == S_REQ);
  assign imem_addr  = r_fetch_pc;
  assign inst_valid = (r_count != '0);
  assign inst       = r_head_data;
  assign inst_pc    = r_head_pc;
  assign count      = r_count;

  // Fetch FSM, fetch address, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_state    <= S_REQ;
      r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_count  <= w_cnt_next;
      r_rd_ptr <= w_rd_next;
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + c_ptr_w'(1);
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      case (r_state)
        S_IDLE:  if (r_count < c_depth) r_state <= S_REQ;
        S_REQ:   if (w_push && (w_cnt_next >= c_depth)) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; written only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      r_mem_data[r_wr_ptr] <= imem_data;
    end
  end

  // Head register: preloads the next head so outputs never see imem_data directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_pc   <= '0;
      r_head_data <= '0;
    end else if (!redirect && (w_cnt_next != '0)) begin
      if (w_head_bypass) begin
        r_head_pc   <= r_fetch_pc;
        r_head_data <= imem_data;
      end else begin
        r_head_pc   <= r_mem_pc[w_rd_next];
        r_head_data <= r_mem_data[w_rd_next];
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  // Free-running counters of accepted fetches and of entries thrown away by redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_fetch_cnt <= r_fetch_cnt + 16'(w_push);
      if (redirect) r_flush_cnt <= r_flush_cnt + 16'(r_count);
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_prefetch_queue
// Description : Self-checking bench for inst_prefetch_queue. A queue-based
//               reference model predicts handshake, occupancy and head
//               contents every cycle; scenario tasks add directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_data = '0;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_ready = 1'b0;
  logic [CW-1:0] count;
`ifdef PREFETCH_STATS_EN
  logic [15:0]   fetch_cnt;
  logic [15:0]   flush_cnt;
  logic [15:0]   m_fetch;
  logic [15:0]   m_flush;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {pc, data}, next fetch address, request flag.
  logic [63:0] mq[$];
  logic [31:0] m_fpc;
  logic        m_req;
  logic [63:0] m_last;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .count       (count)
`ifdef PREFETCH_STATS_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    m_fpc  = RESET_PC;
    m_req  = 1'b0;
    m_last = '0;
`ifdef PREFETCH_STATS_EN
    m_fetch = '0;
    m_flush = '0;
`endif
  endtask

  // Apply inputs for the coming rising edge and advance the model across it.
  task automatic drive(input logic rdy, input logic ack, input logic rdr,
                       input logic [31:0] rpc, input logic [31:0] data);
    int occ;
    bit push;
    bit pop;
    inst_ready  = rdy;
    imem_ack    = ack;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_data   = data;
    if (rdr) begin
`ifdef PREFETCH_STATS_EN
      m_flush = m_flush + 16'(mq.size());
`endif
      mq.delete();
      m_fpc = rpc & 32'hFFFF_FFFC;
      m_req = 1'b1;
    end else begin
      occ  = mq.size();
      pop  = (occ != 0) && rdy;
      push = m_req && ack;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({m_fpc, data});
        m_fpc = m_fpc + 32'd4;
`ifdef PREFETCH_STATS_EN
        m_fetch = m_fetch + 16'd1;
`endif
      end
      if (m_req) begin
        if (push) m_req = (mq.size() < DEPTH);
      end else begin
        m_req = (occ < DEPTH);
      end
    end
  endtask

  // One clock cycle: compare every output with the model, then drive.
  task automatic cycle(input logic rdy, input logic ack, input logic rdr,
                       input logic [31:0] rpc, input logic [31:0] data);
    int n;
    logic [63:0] exp_head;
    @(negedge clk);
    n = mq.size();
    checks++;
    if (imem_req !== m_req) begin
      errors++;
      $display("FAIL model imem_req @%0t: got %b expected %b", $time, imem_req, m_req);
    end
    if (m_req) begin
      checks++;
      if (imem_addr !== m_fpc) begin
        errors++;
        $display("FAIL model imem_addr @%0t: got %h expected %h", $time, imem_addr, m_fpc);
      end
    end
    checks++;
    if (count !== n[CW-1:0]) begin
      errors++;
      $display("FAIL model count @%0t: got %0d expected %0d", $time, count, n);
    end
    checks++;
    if (inst_valid !== (n != 0)) begin
      errors++;
      $display("FAIL model inst_valid @%0t: got %b expected %b", $time, inst_valid, (n != 0));
    end
    exp_head = (n != 0) ? mq[0] : m_last;
    if (n != 0) m_last = mq[0];
    checks++;
    if ({inst_pc, inst} !== exp_head) begin
      errors++;
      $display("FAIL model head @%0t: got pc=%h inst=%h expected pc=%h inst=%h",
               $time, inst_pc, inst, exp_head[63:32], exp_head[31:0]);
    end
`ifdef PREFETCH_STATS_EN
    checks++;
    if (fetch_cnt !== m_fetch) begin
      errors++;
      $display("FAIL model fetch_cnt @%0t: got %0d expected %0d", $time, fetch_cnt, m_fetch);
    end
    checks++;
    if (flush_cnt !== m_flush) begin
      errors++;
      $display("FAIL model flush_cnt @%0t: got %0d expected %0d", $time, flush_cnt, m_flush);
    end
`endif
    drive(rdy, ack, rdr, rpc, data);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    inst_ready = 1'b0; imem_ack = 1'b0; redirect = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || count !== '0 ||
        inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset outputs: got req=%b valid=%b count=%0d inst=%h pc=%h expected all zero",
               imem_req, inst_valid, count, inst, inst_pc);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, $urandom);
      checks++;
      if (imem_addr !== 32'(4 * i) || count > 1) begin
        errors++;
        $display("FAIL stream addr/count cycle %0d: got addr=%h count=%0d expected addr=%h count<=1",
                 i, imem_addr, count, 32'(4 * i));
      end
      if (i > 0) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (i - 1))) begin
          errors++;
          $display("FAIL stream inst_pc cycle %0d: got valid=%b pc=%h expected 1/%h",
                   i, inst_valid, inst_pc, 32'(4 * (i - 1)));
        end
      end
    end
  endtask

  task automatic test_full();
    bit seen;
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, $urandom);
    checks++;
    if (count !== CW'(4) || imem_req !== 1'b0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL full stop: got count=%0d req=%b pc=%h expected 4/0/00000000",
               count, imem_req, inst_pc);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0, $urandom);
      if (imem_req) begin
        seen = 1'b1;
        checks++;
        if (imem_addr !== 32'h10) begin
          errors++;
          $display("FAIL full refill addr: got %h expected 00000010", imem_addr);
        end
      end
    end
    checks++;
    if (!seen || count !== CW'(4) || inst_pc !== 32'h4) begin
      errors++;
      $display("FAIL full refill: got seen_req=%b count=%0d pc=%h expected 1/4/00000004",
               seen, count, inst_pc);
    end
  endtask

  task automatic test_wait();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < 4; w++) begin
        cycle(1'b1, (w == 3), 1'b0, 32'h0, $urandom);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
          errors++;
          $display("FAIL wait addr k=%0d w=%0d: got req=%b addr=%h expected 1/%h",
                   k, w, imem_req, imem_addr, 32'(4 * k));
        end
        if (k > 0 && w == 0) begin
          checks++;
          if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (k - 1))) begin
            errors++;
            $display("FAIL wait inst_pc k=%0d: got valid=%b pc=%h expected 1/%h",
                     k, inst_valid, inst_pc, 32'(4 * (k - 1)));
          end
        end
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, $urandom);
    for (int p = 0; p < 2; p++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, $urandom);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count !== CW'(4) || inst_pc !== 32'h8) begin
      errors++;
      $display("FAIL redirect setup: got count=%0d pc=%h expected 4/00000008", count, inst_pc);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h43, 32'hDEAD_BEEF);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redirect req in flush cycle: got %b expected 1", imem_req);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h1234_5678);
    checks++;
    if (inst_valid !== 1'b0 || count !== '0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redirect after: got valid=%b count=%0d addr=%h req=%b expected 0/0/00000040/1",
               inst_valid, count, imem_addr, imem_req);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== 32'h1234_5678) begin
      errors++;
      $display("FAIL redirect first inst: got valid=%b pc=%h inst=%h expected 1/00000040/12345678",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, $urandom);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count !== CW'(3) || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL async setup: got count=%0d req=%b expected 3/1", count, imem_req);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || count !== '0 ||
        inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL async reset outputs: got req=%b valid=%b count=%0d inst=%h pc=%h expected all zero",
               imem_req, inst_valid, count, inst, inst_pc);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, $urandom);
      checks++;
      if (imem_addr !== RESET_PC + 32'(4 * i)) begin
        errors++;
        $display("FAIL async resume addr %0d: got %h expected %h", i, imem_addr, RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, $urandom);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, $urandom);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h100, 32'hBAD0_BAD0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL stats flush count: got %0d expected 0", count);
    end
`ifdef PREFETCH_STATS_EN
    checks++;
    if (fetch_cnt !== 16'd10 || flush_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stats counters: got fetch=%0d flush=%0d expected 10/3", fetch_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 99) < 4), $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_wait();
    test_redirect();
    test_async_reset();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
